// File: rtl/softmax_normalizer.sv
// softmax_normalizer: final softmax stage.
//   Buffers one frame of Q0.16 exp values and takes the frame's Q5.11 sum from
//   Adder_block. It computes one reciprocal R = floor(2^27 / S) per frame by
//   serial restoring division, then streams P = (E * R) >> 16 as saturated
//   Q0.16 probabilities.
// Build option: define SOFTMAX_NORM_ROUND_EN to round the product half-up
//   before the >>16. When it is undefined the product is truncated. R is
//   truncated in both builds.
// Ports:
//   iClk, iRsn                       clock, async active-low reset
//   iValid/oReady/iLast/iData        exp element stream in (Q0.16)
//   iSumValid/oSumReady/iSumData     frame sum in (Q5.11)
//   oValid/iReady/oData/oLast        probability stream out (Q0.16)
//   oOverflow                        sticky, current frame exceeded DEPTH
module softmax_normalizer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic        iClk,
  input  logic        iRsn,
  input  logic        iValid,
  output logic        oReady,
  input  logic        iLast,
  input  logic [15:0] iData,
  input  logic        iSumValid,
  output logic        oSumReady,
  input  logic [15:0] iSumData,
  output logic        oValid,
  input  logic        iReady,
  output logic [15:0] oData,
  output logic        oLast,
  output logic        oOverflow
);

  localparam int unsigned DW = 16;        // element / sum width
  localparam int unsigned CW = AW + 1;    // count must reach DEPTH itself
  localparam int unsigned QW = 28;        // reciprocal quotient width
  localparam int unsigned PW = DW + QW;   // full product width
  localparam int unsigned SW = PW - 16;   // product after >>16
  localparam int unsigned IW = 5;         // division step counter

  typedef enum logic [1:0] {
    ST_FILL,
    ST_WAIT_SUM,
    ST_RECIP,
    ST_EMIT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            sum_ready_q, sum_ready_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [DW-1:0]   s1_data_q, s1_data_d;
  logic            s1_last_q, s1_last_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  logic [DW-1:0]   mem_q [DEPTH];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;

  logic            in_fire, sum_fire, out_fire, advance;
  logic [DW:0]     div_shift;
  logic            div_ge;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   prod_adj;
  logic [SW-1:0]   prod_sh;
  logic [DW-1:0]   prob;

  assign oReady    = in_ready_q;
  assign oSumReady = sum_ready_q;
  assign oValid    = out_valid_q;
  assign oData     = out_data_q;
  assign oLast     = out_last_q;
  assign oOverflow = ovf_q;

  assign in_fire  = iValid && in_ready_q;
  assign sum_fire = iSumValid && sum_ready_q;
  assign out_fire = out_valid_q && iReady;
  // The whole read/multiply pipe freezes while a result is held downstream.
  assign advance  = !out_valid_q || iReady;

  // One restoring-division step: shift the next dividend bit into the remainder.
  assign div_shift = {rem_q, quo_q[QW-1]};
  assign div_ge    = div_shift >= {1'b0, sum_q};

  // Probability for the element in stage 1, saturated to Q0.16.
  always_comb begin
    prod = PW'(s1_data_q) * PW'(quo_q);
`ifdef SOFTMAX_NORM_ROUND_EN
    prod_adj = prod + PW'(32'd32768);
`else
    prod_adj = prod;
`endif
    prod_sh = SW'(prod_adj >> 16);
    prob    = (prod_sh > SW'(32'hFFFF)) ? 16'hFFFF : prod_sh[DW-1:0];
  end

  // Next-state, datapath and pipe control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    iter_d      = iter_q;
    rd_ptr_d    = rd_ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    wr_en       = 1'b0;
    wr_addr     = cnt_q[AW-1:0];

    case (state_q)
      ST_FILL: begin
        if (in_fire) begin
          if (cnt_q == '0) begin
            ovf_d = 1'b0;
          end
          if (cnt_q == CW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
          if (iLast) begin
            state_d = ST_WAIT_SUM;
          end
        end
      end

      ST_WAIT_SUM: begin
        if (sum_fire) begin
          sum_d  = iSumData;
          rem_d  = '0;
          iter_d = '0;
          if (iSumData == '0) begin
            // A zero sum gives R = 0, so every output of the frame is zero.
            quo_d   = '0;
            state_d = ST_EMIT;
          end else begin
            quo_d   = QW'(1) << (QW - 1);
            state_d = ST_RECIP;
          end
        end
      end

      ST_RECIP: begin
        rem_d  = div_ge ? DW'(div_shift - {1'b0, sum_q}) : div_shift[DW-1:0];
        quo_d  = {quo_q[QW-2:0], div_ge};
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(QW - 1)) begin
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (out_fire && out_last_q) begin
          state_d  = ST_FILL;
          cnt_d    = '0;
          rd_ptr_d = '0;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase

    // Stage 1 is the registered buffer read; stage 2 is the multiply and output register.
    if (advance) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_data_d = prob;
      end
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      if ((state_q == ST_EMIT) && (rd_ptr_q < cnt_q)) begin
        s1_valid_d = 1'b1;
        s1_data_d  = mem_q[rd_ptr_q[AW-1:0]];
        s1_last_d  = (rd_ptr_q == (cnt_q - CW'(1)));
        rd_ptr_d   = rd_ptr_q + CW'(1);
      end
    end

    in_ready_d  = (state_d == ST_FILL);
    sum_ready_d = (state_d == ST_WAIT_SUM);
  end

  // Control and datapath registers.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      sum_ready_q <= 1'b0;
      sum_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      iter_q      <= '0;
      rd_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      sum_ready_q <= sum_ready_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      iter_q      <= iter_d;
      rd_ptr_q    <= rd_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Frame buffer storage; its contents are don't-care after reset.
  always_ff @(posedge iClk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= iData;
    end
  end

endmodule

// File: tb/tb_softmax_normalizer.sv
// tb_softmax_normalizer: directed self-checking bench for softmax_normalizer.
module tb_softmax_normalizer;

  localparam int DEPTH = 64;

  logic        iClk = 1'b0;
  logic        iRsn = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic        iLast = 1'b0;
  logic [15:0] iData = '0;
  logic        iSumValid = 1'b0;
  logic        oSumReady;
  logic [15:0] iSumData = '0;
  logic        oValid;
  logic        iReady = 1'b1;
  logic [15:0] oData;
  logic        oLast;
  logic        oOverflow;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [15:0] cap_data[$];
  bit          cap_last[$];
  int          first_cyc;

  softmax_normalizer #(.DEPTH(DEPTH), .AW(6)) dut (
    .iClk(iClk), .iRsn(iRsn),
    .iValid(iValid), .oReady(oReady), .iLast(iLast), .iData(iData),
    .iSumValid(iSumValid), .oSumReady(oSumReady), .iSumData(iSumData),
    .oValid(oValid), .iReady(iReady), .oData(oData), .oLast(oLast),
    .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  function automatic logic [15:0] ovf_val(input int i);
    return 16'(i * 257 + 3);
  endfunction

  // Drive one element; returns #1 after the edge on which it transferred.
  task automatic send_elem(input logic [15:0] d, input logic last);
    int t = 0;
    @(negedge iClk);
    iValid = 1'b1; iData = d; iLast = last;
    while (!oReady && t < 200) begin
      @(negedge iClk);
      t++;
    end
    if (t >= 200) begin
      tests++; fails++;
      $display("FAIL send_elem_timeout: oReady=%b required 1", oReady);
    end
    @(posedge iClk);
    #1;
    iValid = 1'b0; iLast = 1'b0;
  endtask

  // Offer the frame sum; fire_cyc is the cycle count of the accepting edge.
  task automatic send_sum(input logic [15:0] s, output int fire_cyc);
    int t = 0;
    @(negedge iClk);
    iSumValid = 1'b1; iSumData = s;
    while (!oSumReady && t < 200) begin
      @(negedge iClk);
      t++;
    end
    if (t >= 200) begin
      tests++; fails++;
      $display("FAIL send_sum_timeout: oSumReady=%b required 1", oSumReady);
    end
    @(posedge iClk);
    #1;
    fire_cyc = cyc;
    iSumValid = 1'b0;
  endtask

  // Record outputs with iReady=1 until oLast, an over-long stream, or timeout.
  task automatic collect(input int n);
    cap_data.delete();
    cap_last.delete();
    first_cyc = -1;
    iReady = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge iClk);
      if (oValid) begin
        if (first_cyc < 0) first_cyc = cyc;
        cap_data.push_back(oData);
        cap_last.push_back(oLast);
        if (oLast || cap_data.size() > n + 2) break;
      end
    end
    @(posedge iClk);
  endtask

  task automatic test_reset();
    iRsn = 1'b0;
    repeat (3) @(negedge iClk);
    tests++;
    if ({oValid, oLast, oOverflow, oSumReady} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got v/l/ovf/sr=%b required 0000", {oValid, oLast, oOverflow, oSumReady});
    end
    tests++;
    if (oData !== 16'h0000) begin
      fails++;
      $display("FAIL reset_data: got %h required 0000", oData);
    end
    iRsn = 1'b1;
    @(negedge iClk);
    tests++;
    if (oReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b required 1", oReady);
    end
  endtask

  task automatic test_basic();
    int f;
    for (int i = 0; i < 4; i++) send_elem(16'h4000, i == 3);
    send_sum(16'h0800, f);
    collect(4);
    tests++;
    if (cap_data.size() != 4) begin
      fails++;
      $display("FAIL basic_count: got %0d required 4", cap_data.size());
    end
    for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
      tests++;
      if (cap_data[i] !== 16'h4000 || cap_last[i] !== (i == 3)) begin
        fails++;
        $display("FAIL basic_elem%0d: got %h last=%b required 4000 last=%b", i, cap_data[i], cap_last[i], i == 3);
      end
    end
    tests++;
    if (first_cyc - f != 30) begin
      fails++;
      $display("FAIL basic_latency: got %0d required 30", first_cyc - f);
    end
    @(negedge iClk);
    tests++;
    if (oReady !== 1'b1 || oSumReady !== 1'b0) begin
      fails++;
      $display("FAIL basic_back_to_fill: got rdy=%b srdy=%b required 1 0", oReady, oSumReady);
    end
  endtask

  task automatic test_saturate();
    int f;
    send_elem(16'hFFFF, 1'b1);
    send_sum(16'h0400, f);
    collect(1);
    tests++;
    if (cap_data.size() != 1 || cap_data[0] !== 16'hFFFF || cap_last[0] !== 1'b1) begin
      fails++;
      $display("FAIL saturate: got n=%0d data=%h required n=1 data=ffff last=1", cap_data.size(), cap_data[0]);
    end
  endtask

  task automatic test_round();
    int f;
    logic [15:0] exp_v;
`ifdef SOFTMAX_NORM_ROUND_EN
    exp_v = 16'h02AB;
`else
    exp_v = 16'h02AA;
`endif
    send_elem(16'h0001, 1'b1);
    send_sum(16'h0003, f);
    collect(1);
    tests++;
    if (cap_data.size() != 1 || cap_data[0] !== exp_v || cap_last[0] !== 1'b1) begin
      fails++;
      $display("FAIL round: got n=%0d data=%h required n=1 data=%h", cap_data.size(), cap_data[0], exp_v);
    end
  endtask

  task automatic test_zero_sum();
    int f;
    send_elem(16'h1234, 1'b0);
    send_elem(16'hFFFF, 1'b0);
    send_elem(16'h0001, 1'b1);
    send_sum(16'h0000, f);
    collect(3);
    tests++;
    if (cap_data.size() != 3) begin
      fails++;
      $display("FAIL zero_count: got %0d required 3", cap_data.size());
    end
    for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
      tests++;
      if (cap_data[i] !== 16'h0000 || cap_last[i] !== (i == 2)) begin
        fails++;
        $display("FAIL zero_elem%0d: got %h last=%b required 0000 last=%b", i, cap_data[i], cap_last[i], i == 2);
      end
    end
  endtask

  task automatic test_overflow();
    int f;
    for (int k = 1; k <= DEPTH + 3; k++) begin
      send_elem(ovf_val(k - 1), k == DEPTH + 3);
      tests++;
      if (oOverflow !== (k >= DEPTH + 1)) begin
        fails++;
        $display("FAIL ovf_flag_k%0d: got %b required %b", k, oOverflow, k >= DEPTH + 1);
      end
    end
    send_sum(16'h0800, f);
    collect(DEPTH);
    tests++;
    if (cap_data.size() != DEPTH) begin
      fails++;
      $display("FAIL ovf_count: got %0d required %0d", cap_data.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < cap_data.size(); i++) begin
      tests++;
      if (cap_data[i] !== ovf_val(i) || cap_last[i] !== (i == DEPTH - 1)) begin
        fails++;
        $display("FAIL ovf_elem%0d: got %h last=%b required %h last=%b", i, cap_data[i], cap_last[i], ovf_val(i), i == DEPTH - 1);
      end
    end
    @(negedge iClk);
    tests++;
    if (oOverflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: got %b required 1", oOverflow);
    end
    send_elem(16'h2000, 1'b1);
    tests++;
    if (oOverflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b required 0", oOverflow);
    end
    send_sum(16'h0800, f);
    collect(1);
    tests++;
    if (cap_data.size() != 1 || cap_data[0] !== 16'h2000 || cap_last[0] !== 1'b1) begin
      fails++;
      $display("FAIL ovf_next_frame: got n=%0d data=%h required n=1 data=2000", cap_data.size(), cap_data[0]);
    end
  endtask

  task automatic test_backpressure();
    int f;
    logic [15:0] vals[5];
    logic [15:0] got_d[$];
    bit          got_l[$];
    bit          held = 1'b0;
    logic [15:0] held_d = '0;
    bit          held_l = 1'b0;
    bit          ph = 1'b0;
    vals[0] = 16'h1000; vals[1] = 16'h0FFF; vals[2] = 16'h8000;
    vals[3] = 16'h0001; vals[4] = 16'hABCD;
    for (int i = 0; i < 5; i++) send_elem(vals[i], i == 4);
    send_sum(16'h0800, f);
    for (int t = 0; t < 300; t++) begin
      @(negedge iClk);
      if (held) begin
        tests++;
        if (oValid !== 1'b1 || oData !== held_d || oLast !== held_l) begin
          fails++;
          $display("FAIL bp_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b", oValid, oData, oLast, held_d, held_l);
        end
      end
      iReady = ph;
      ph = ~ph;
      held = oValid && !iReady;
      held_d = oData;
      held_l = oLast;
      if (oValid && iReady) begin
        got_d.push_back(oData);
        got_l.push_back(oLast);
        if (oLast) break;
      end
    end
    @(posedge iClk);
    #1;
    iReady = 1'b1;
    tests++;
    if (got_d.size() != 5) begin
      fails++;
      $display("FAIL bp_count: got %0d required 5", got_d.size());
    end
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      tests++;
      if (got_d[i] !== vals[i] || got_l[i] !== (i == 4)) begin
        fails++;
        $display("FAIL bp_elem%0d: got %h last=%b required %h last=%b", i, got_d[i], got_l[i], vals[i], i == 4);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int f;
    int t = 0;
    for (int i = 0; i < 4; i++) send_elem(16'h3000, i == 3);
    iReady = 1'b0;
    send_sum(16'h0800, f);
    while (!oValid && t < 100) begin
      @(negedge iClk);
      t++;
    end
    tests++;
    if (oValid !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_reach_emit: got oValid=%b required 1", oValid);
    end
    @(negedge iClk);
    iRsn = 1'b0;
    #1;
    tests++;
    if ({oValid, oLast, oSumReady, oOverflow} !== 4'b0000 || oData !== 16'h0000) begin
      fails++;
      $display("FAIL rst_mid_outputs: got v/l/sr/ovf=%b d=%h required 0000 d=0000", {oValid, oLast, oSumReady, oOverflow}, oData);
    end
    @(negedge iClk);
    iRsn = 1'b1;
    iReady = 1'b1;
    send_elem(16'h0100, 1'b0);
    send_elem(16'h0200, 1'b1);
    send_sum(16'h0800, f);
    collect(2);
    tests++;
    if (cap_data.size() != 2) begin
      fails++;
      $display("FAIL rst_mid_count: got %0d required 2", cap_data.size());
    end
    tests++;
    if (cap_data[0] !== 16'h0100 || cap_data[1] !== 16'h0200 || cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_data: got %h/%h last=%b%b required 0100/0200 last=01", cap_data[0], cap_data[1], cap_last[0], cap_last[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_round();
    test_zero_sum();
    test_overflow();
    test_backpressure();
    test_reset_mid_emit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
